// File: rtl/multicycle_ctrl_fsm.sv
// Multi-cycle control FSM for the MIPS-subset CPU.
// Sequences fetch / decode / execute / memory / writeback, plus mult/div
// start-wait handshakes guarded by a watchdog and a sticky trap state.
//
// Memory handshake: while the FSM sits in FETCH or MEM it holds its request
// (MemRead or MemWrite) high; mem_ready acts as the ready side and the access
// completes on the rising edge where mem_ready is 1. Nothing that commits
// the access (IRWrite, PCWrite, state advance) happens before that edge.
module multicycle_ctrl_fsm #(
    parameter int ALUOP_W    = 4,
    parameter int MD_TIMEOUT = 64,
    parameter int TO_CNT_W   = 7
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic [5:0]         opcode,
    input  logic [5:0]         funct,
    input  logic               mem_ready,
    input  logic               mult_done_in,
    input  logic               div_done_in,
    output logic               PCWrite,
    output logic               PCWriteCond,
    output logic               PCWriteCondNeg,
    output logic               IorD,
    output logic               MemRead,
    output logic               MemWrite,
    output logic               IRWrite,
    output logic               RegWrite,
    output logic               ALUSrcA,
    output logic               HIWrite,
    output logic               LOWrite,
    output logic               MultStart,
    output logic               DivStart,
    output logic [1:0]         RegDst,
    output logic [1:0]         ALUSrcB,
    output logic [1:0]         PCSource,
    output logic [ALUOP_W-1:0] ALUOp,
    output logic [2:0]         WBDataSrc,
    output logic               illegal_op,
    output logic               md_timeout,
    output logic [3:0]         state_out
);

    typedef enum logic [3:0] {
        S_RESET    = 4'd0,
        S_FETCH    = 4'd1,
        S_DECODE   = 4'd2,
        S_EXEC_R   = 4'd3,
        S_EXEC_I   = 4'd4,
        S_MEM      = 4'd5,
        S_WB       = 4'd6,
        S_BRANCH   = 4'd7,
        S_MD_START = 4'd8,
        S_MD_WAIT  = 4'd9,
        S_TRAP     = 4'd10
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] F_MFHI = 6'h10;
    localparam logic [5:0] F_MFLO = 6'h12;
    localparam logic [5:0] F_MULT = 6'h18;
    localparam logic [5:0] F_DIV  = 6'h1A;
    localparam logic [5:0] F_ADD  = 6'h20;
    localparam logic [5:0] F_SUB  = 6'h22;
    localparam logic [5:0] F_AND  = 6'h24;
    localparam logic [5:0] F_OR   = 6'h25;
    localparam logic [5:0] F_SLT  = 6'h2A;

    localparam logic [ALUOP_W-1:0] ALU_ADD = ALUOP_W'(1);
    localparam logic [ALUOP_W-1:0] ALU_SUB = ALUOP_W'(2);
    localparam logic [ALUOP_W-1:0] ALU_AND = ALUOP_W'(3);
    localparam logic [ALUOP_W-1:0] ALU_OR  = ALUOP_W'(4);
    localparam logic [ALUOP_W-1:0] ALU_SLT = ALUOP_W'(5);

    // Last watchdog value: MD_WAIT cycle number MD_TIMEOUT sees this count.
    localparam logic [TO_CNT_W-1:0] CNT_LAST = TO_CNT_W'(MD_TIMEOUT - 1);

    state_t              state_q, state_d;
    logic [TO_CNT_W-1:0] cnt_q, cnt_d;
    logic                ill_q, ill_d;
    logic                tmo_q, tmo_d;

    logic                is_r;
    logic                r_alu;
    logic                r_md;
    logic                r_mf;
    logic                md_is_mult;
    logic                md_done;
    logic [ALUOP_W-1:0]  r_alu_op;

    // Instruction classification from the IR fields.
    always_comb begin
        is_r       = (opcode == OP_RTYPE);
        r_alu      = is_r && ((funct == F_ADD) || (funct == F_SUB) || (funct == F_AND) ||
                              (funct == F_OR)  || (funct == F_SLT));
        r_md       = is_r && ((funct == F_MULT) || (funct == F_DIV));
        r_mf       = is_r && ((funct == F_MFHI) || (funct == F_MFLO));
        md_is_mult = (funct == F_MULT);
        // Only the unit that was started can complete the wait.
        md_done    = md_is_mult ? mult_done_in : div_done_in;
    end

    // ALU operation for R-type arithmetic, selected by funct.
    always_comb begin
        r_alu_op = ALU_ADD;
        case (funct)
            F_ADD:   r_alu_op = ALU_ADD;
            F_SUB:   r_alu_op = ALU_SUB;
            F_AND:   r_alu_op = ALU_AND;
            F_OR:    r_alu_op = ALU_OR;
            F_SLT:   r_alu_op = ALU_SLT;
            default: r_alu_op = ALU_ADD;
        endcase
    end

    // Next-state, watchdog, sticky flags and all datapath controls.
    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        ill_d          = ill_q;
        tmo_d          = tmo_q;
        PCWrite        = 1'b0;
        PCWriteCond    = 1'b0;
        PCWriteCondNeg = 1'b0;
        IorD           = 1'b0;
        MemRead        = 1'b0;
        MemWrite       = 1'b0;
        IRWrite        = 1'b0;
        RegWrite       = 1'b0;
        ALUSrcA        = 1'b0;
        HIWrite        = 1'b0;
        LOWrite        = 1'b0;
        MultStart      = 1'b0;
        DivStart       = 1'b0;
        RegDst         = 2'b00;
        ALUSrcB        = 2'b00;
        PCSource       = 2'b00;
        ALUOp          = '0;
        WBDataSrc      = 3'b000;

        case (state_q)
            S_RESET: begin
                state_d = S_FETCH;
            end
            S_FETCH: begin
                // PC+4 is computed every fetch cycle but only committed with the IR.
                MemRead = 1'b1;
                ALUSrcB = 2'b01;
                ALUOp   = ALU_ADD;
                IRWrite = mem_ready;
                PCWrite = mem_ready;
                if (mem_ready) state_d = S_DECODE;
            end
            S_DECODE: begin
                if (r_md)                                          state_d = S_MD_START;
                else if (r_mf)                                     state_d = S_WB;
                else if (r_alu)                                    state_d = S_EXEC_R;
                else if ((opcode == OP_LW) || (opcode == OP_SW) ||
                         (opcode == OP_ADDI))                      state_d = S_EXEC_I;
                else if ((opcode == OP_BEQ) || (opcode == OP_BNE)) state_d = S_BRANCH;
                else if (opcode == OP_J) begin
                    PCWrite  = 1'b1;
                    PCSource = 2'b10;
                    state_d  = S_FETCH;
                end else begin
                    state_d = S_TRAP;
                    ill_d   = 1'b1;
                end
            end
            S_EXEC_R: begin
                ALUSrcA = 1'b1;
                ALUOp   = r_alu_op;
                state_d = S_WB;
            end
            S_EXEC_I: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
                ALUOp   = ALU_ADD;
                state_d = (opcode == OP_ADDI) ? S_WB : S_MEM;
            end
            S_MEM: begin
                IorD = 1'b1;
                if (opcode == OP_SW) begin
                    MemWrite = 1'b1;
                    if (mem_ready) state_d = S_FETCH;
                end else begin
                    MemRead = 1'b1;
                    if (mem_ready) state_d = S_WB;
                end
            end
            S_WB: begin
                RegWrite = 1'b1;
                if (is_r) begin
                    RegDst = 2'b01;
                    case (funct)
                        F_SLT:   WBDataSrc = 3'b101;
                        F_MFHI:  WBDataSrc = 3'b010;
                        F_MFLO:  WBDataSrc = 3'b011;
                        default: WBDataSrc = 3'b000;
                    endcase
                end else if (opcode == OP_LW) begin
                    WBDataSrc = 3'b001;
                end
                state_d = S_FETCH;
            end
            S_BRANCH: begin
                // Datapath compares via SUB; bne uses the inverted-zero write enable.
                ALUSrcA        = 1'b1;
                ALUOp          = ALU_SUB;
                PCWriteCond    = (opcode == OP_BEQ);
                PCWriteCondNeg = (opcode == OP_BNE);
                state_d        = S_FETCH;
            end
            S_MD_START: begin
                MultStart = md_is_mult;
                DivStart  = !md_is_mult;
                cnt_d     = '0;
                state_d   = S_MD_WAIT;
            end
            S_MD_WAIT: begin
                // Done takes priority over the watchdog in the final allowed cycle.
                if (md_done) begin
                    HIWrite = 1'b1;
                    LOWrite = 1'b1;
                    state_d = S_FETCH;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = S_TRAP;
                    tmo_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q + TO_CNT_W'(1);
                end
            end
            S_TRAP: begin
                state_d = S_TRAP;
            end
            default: begin
                state_d = S_RESET;
            end
        endcase
    end

    // State, watchdog and sticky flags; everything clears asynchronously.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_RESET;
            cnt_q   <= '0;
            ill_q   <= 1'b0;
            tmo_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ill_q   <= ill_d;
            tmo_q   <= tmo_d;
        end
    end

    assign illegal_op = ill_q;
    assign md_timeout = tmo_q;
    assign state_out  = state_q;

endmodule

// File: tb/tb_multicycle_ctrl_fsm.sv
// Bench for multicycle_ctrl_fsm: each instruction is expanded into its
// expected cycle-by-cycle trace from the instruction-level rules, and a
// compare process checks every DUT output on every cycle.
module tb_multicycle_ctrl_fsm;

    localparam int T = 16;

    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic       pc_write_cond_neg;
        logic       iord;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       reg_write;
        logic       alu_src_a;
        logic       hi_write;
        logic       lo_write;
        logic       mult_start;
        logic       div_start;
        logic [1:0] reg_dst;
        logic [1:0] alu_src_b;
        logic [1:0] pc_source;
        logic [3:0] alu_op;
        logic [2:0] wb_src;
        logic       ill;
        logic       tmo;
        logic [3:0] state;
    } out_t;

    localparam int C_RALU = 0, C_MD = 1, C_MF = 2, C_ADDI = 3, C_LW = 4,
                   C_SW = 5, C_BR = 6, C_J = 7, C_ILL = 8;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic [5:0] opcode = '0;
    logic [5:0] funct = '0;
    logic       mem_ready = 1'b0;
    logic       mult_done_in = 1'b0;
    logic       div_done_in = 1'b0;
    logic       PCWrite, PCWriteCond, PCWriteCondNeg, IorD, MemRead, MemWrite;
    logic       IRWrite, RegWrite, ALUSrcA, HIWrite, LOWrite, MultStart, DivStart;
    logic [1:0] RegDst, ALUSrcB, PCSource;
    logic [3:0] ALUOp;
    logic [2:0] WBDataSrc;
    logic       illegal_op, md_timeout;
    logic [3:0] state_out;

    out_t        act;
    logic [31:0] exp_q[$];
    int          checks = 0;
    int          errors = 0;
    int          cyc_no = 0;
    logic        ill_m = 1'b0;
    logic        to_m = 1'b0;
    logic [5:0]  legal_op[15];
    logic [5:0]  legal_fn[15];

    multicycle_ctrl_fsm #(.ALUOP_W(4), .MD_TIMEOUT(T), .TO_CNT_W(5)) dut (
        .clk(clk), .reset_n(reset_n), .opcode(opcode), .funct(funct),
        .mem_ready(mem_ready), .mult_done_in(mult_done_in), .div_done_in(div_done_in),
        .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .PCWriteCondNeg(PCWriteCondNeg),
        .IorD(IorD), .MemRead(MemRead), .MemWrite(MemWrite), .IRWrite(IRWrite),
        .RegWrite(RegWrite), .ALUSrcA(ALUSrcA), .HIWrite(HIWrite), .LOWrite(LOWrite),
        .MultStart(MultStart), .DivStart(DivStart), .RegDst(RegDst), .ALUSrcB(ALUSrcB),
        .PCSource(PCSource), .ALUOp(ALUOp), .WBDataSrc(WBDataSrc),
        .illegal_op(illegal_op), .md_timeout(md_timeout), .state_out(state_out)
    );

    assign act = {PCWrite, PCWriteCond, PCWriteCondNeg, IorD, MemRead, MemWrite,
                  IRWrite, RegWrite, ALUSrcA, HIWrite, LOWrite, MultStart, DivStart,
                  RegDst, ALUSrcB, PCSource, ALUOp, WBDataSrc, illegal_op,
                  md_timeout, state_out};

    // Clock.
    always #5 clk = ~clk;

    // Run-time bound.
    initial begin
        #500000;
        $display("FAIL run_time_bound: simulation did not finish, got timeout expected finish");
        $fatal(1, "time bound expired");
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, want);
        end
    endtask

    // Scoreboard: one expected output vector per cycle, checked mid-cycle.
    always begin
        @(negedge clk);
        #2;
        if (exp_q.size() > 0) begin
            out_t e;
            e = exp_q.pop_front();
            cyc_no++;
            check($sformatf("cycle%0d_state%0d", cyc_no, e.state), act, e);
        end
    end

    function automatic logic rb();
        return 1'($urandom_range(0, 1));
    endfunction

    function automatic out_t idle();
        out_t o;
        o     = '0;
        o.ill = ill_m;
        o.tmo = to_m;
        return o;
    endfunction

    function automatic int classify(input logic [5:0] op, input logic [5:0] fn);
        if (op == 6'h00) begin
            case (fn)
                6'h20, 6'h22, 6'h24, 6'h25, 6'h2A: return C_RALU;
                6'h18, 6'h1A:                      return C_MD;
                6'h10, 6'h12:                      return C_MF;
                default:                           return C_ILL;
            endcase
        end
        case (op)
            6'h08:        return C_ADDI;
            6'h23:        return C_LW;
            6'h2B:        return C_SW;
            6'h04, 6'h05: return C_BR;
            6'h02:        return C_J;
            default:      return C_ILL;
        endcase
    endfunction

    function automatic logic [3:0] alu_of(input logic [5:0] fn);
        case (fn)
            6'h22:   return 4'd2;
            6'h24:   return 4'd3;
            6'h25:   return 4'd4;
            6'h2A:   return 4'd5;
            default: return 4'd1;
        endcase
    endfunction

    // Driver: one clock cycle of stimulus plus the outputs that cycle must show.
    task automatic step(input logic rn, input logic [5:0] op, input logic [5:0] fn,
                        input logic mr, input logic md, input logic dd, input out_t e);
        @(negedge clk);
        reset_n      = rn;
        opcode       = op;
        funct        = fn;
        mem_ready    = mr;
        mult_done_in = md;
        div_done_in  = dd;
        exp_q.push_back(e);
    endtask

    task automatic trap_cycles(input logic [5:0] op, input logic [5:0] fn);
        out_t e;
        for (int i = 0; i < 3; i++) begin
            e       = idle();
            e.state = 4'd10;
            step(1'b1, op, fn, rb(), rb(), rb(), e);
        end
    endtask

    // Expands one instruction into its per-cycle trace. ncyc counts the
    // instruction's own cycles (trap cycles excluded).
    task automatic run_instr(input logic [5:0] op, input logic [5:0] fn,
                             input int fwait, input int mwait, input int k,
                             input int abort_at, output int ncyc);
        out_t e;
        int   c;
        logic is_mult, fin, hit;
        ncyc = 0;
        c    = classify(op, fn);
        for (int i = 0; i <= fwait; i++) begin
            e = idle(); e.state = 4'd1; e.mem_read = 1'b1; e.alu_src_b = 2'b01; e.alu_op = 4'd1;
            e.ir_write = (i == fwait);
            e.pc_write = (i == fwait);
            step(1'b1, op, fn, (i == fwait), rb(), rb(), e);
            ncyc++;
        end
        e = idle(); e.state = 4'd2;
        if (c == C_J) begin
            e.pc_write  = 1'b1;
            e.pc_source = 2'b10;
        end
        step(1'b1, op, fn, rb(), rb(), rb(), e);
        ncyc++;
        case (c)
            C_ILL: begin
                ill_m = 1'b1;
                trap_cycles(op, fn);
            end
            C_RALU, C_MF: begin
                if (c == C_RALU) begin
                    e = idle(); e.state = 4'd3; e.alu_src_a = 1'b1; e.alu_op = alu_of(fn);
                    step(1'b1, op, fn, rb(), rb(), rb(), e);
                    ncyc++;
                end
                e = idle(); e.state = 4'd6; e.reg_write = 1'b1; e.reg_dst = 2'b01;
                e.wb_src = (fn == 6'h2A) ? 3'b101 : (fn == 6'h10) ? 3'b010 :
                           (fn == 6'h12) ? 3'b011 : 3'b000;
                step(1'b1, op, fn, rb(), rb(), rb(), e);
                ncyc++;
            end
            C_ADDI, C_LW, C_SW: begin
                e = idle(); e.state = 4'd4; e.alu_src_a = 1'b1; e.alu_src_b = 2'b10; e.alu_op = 4'd1;
                step(1'b1, op, fn, rb(), rb(), rb(), e);
                ncyc++;
                if (c != C_ADDI) begin
                    for (int i = 0; i <= mwait; i++) begin
                        e = idle(); e.state = 4'd5; e.iord = 1'b1;
                        e.mem_read  = (c == C_LW);
                        e.mem_write = (c == C_SW);
                        step(1'b1, op, fn, (i == mwait), rb(), rb(), e);
                        ncyc++;
                    end
                end
                if (c != C_SW) begin
                    e = idle(); e.state = 4'd6; e.reg_write = 1'b1;
                    e.wb_src = (c == C_LW) ? 3'b001 : 3'b000;
                    step(1'b1, op, fn, rb(), rb(), rb(), e);
                    ncyc++;
                end
            end
            C_BR: begin
                e = idle(); e.state = 4'd7; e.alu_src_a = 1'b1; e.alu_op = 4'd2;
                e.pc_write_cond     = (op == 6'h04);
                e.pc_write_cond_neg = (op == 6'h05);
                step(1'b1, op, fn, rb(), rb(), rb(), e);
                ncyc++;
            end
            C_MD: begin
                is_mult = (fn == 6'h18);
                e = idle(); e.state = 4'd8; e.mult_start = is_mult; e.div_start = !is_mult;
                step(1'b1, op, fn, rb(), rb(), rb(), e);
                ncyc++;
                fin = 1'b0;
                for (int i = 1; i <= T && !fin; i++) begin
                    if (abort_at != 0 && i > abort_at) begin
                        fin = 1'b1;
                    end else begin
                        hit = (i == k);
                        e = idle(); e.state = 4'd9; e.hi_write = hit; e.lo_write = hit;
                        step(1'b1, op, fn, rb(), is_mult ? hit : rb(), is_mult ? rb() : hit, e);
                        ncyc++;
                        if (hit) begin
                            fin = 1'b1;
                        end else if (i == T) begin
                            to_m = 1'b1;
                            trap_cycles(op, fn);
                            fin = 1'b1;
                        end
                    end
                end
            end
            default: ;
        endcase
    endtask

    // Asynchronous reset mid-cycle, then one held cycle and a release cycle.
    task automatic do_reset();
        out_t z;
        @(negedge clk);
        #4;
        reset_n = 1'b0;
        #1;
        check("async_reset_outputs", act, 32'h0);
        ill_m = 1'b0;
        to_m  = 1'b0;
        z     = '0;
        step(1'b0, 6'h00, 6'h18, 1'b1, rb(), rb(), z);
        step(1'b1, 6'h00, 6'h18, 1'b1, rb(), rb(), z);
    endtask

    initial begin
        int n;
        legal_op = '{6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00,
                     6'h08, 6'h23, 6'h2B, 6'h04, 6'h05, 6'h02};
        legal_fn = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A, 6'h18, 6'h1A, 6'h10, 6'h12,
                     6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00};

        do_reset();

        run_instr(6'h00, 6'h20, 0, 0, 0, 0, n); check("cpi_add", n, 4);
        run_instr(6'h23, 6'h00, 0, 2, 0, 0, n); check("cpi_lw_2wait", n, 7);
        run_instr(6'h2B, 6'h00, 0, 0, 0, 0, n); check("cpi_sw", n, 4);
        run_instr(6'h08, 6'h00, 1, 0, 0, 0, n); check("cpi_addi_fetchwait", n, 5);
        run_instr(6'h04, 6'h00, 0, 0, 0, 0, n); check("cpi_beq", n, 3);
        run_instr(6'h05, 6'h00, 0, 0, 0, 0, n); check("cpi_bne", n, 3);
        run_instr(6'h02, 6'h00, 0, 0, 0, 0, n); check("cpi_j", n, 2);
        run_instr(6'h00, 6'h10, 0, 0, 0, 0, n); check("cpi_mfhi", n, 3);
        run_instr(6'h00, 6'h2A, 0, 0, 0, 0, n); check("cpi_slt", n, 4);
        run_instr(6'h00, 6'h18, 0, 0, 5, 0, n); check("cpi_mult_k5", n, 8);
        run_instr(6'h00, 6'h1A, 0, 0, T, 0, n); check("cpi_div_done_last", n, 3 + T);
        check("no_trap_on_last_done", {31'b0, md_timeout}, 32'h0);
        run_instr(6'h00, 6'h22, 0, 0, 0, 0, n);

        run_instr(6'h00, 6'h1A, 0, 0, 0, 0, n);
        check("md_timeout_set", {31'b0, md_timeout}, 32'h1);
        do_reset();

        run_instr(6'h00, 6'h18, 0, 0, 0, 10, n);
        do_reset();

        run_instr(6'h3F, 6'h00, 0, 0, 0, 0, n);
        check("illegal_op_opcode", {31'b0, illegal_op}, 32'h1);
        do_reset();
        check("illegal_op_cleared", {31'b0, illegal_op}, 32'h0);
        run_instr(6'h00, 6'h01, 0, 0, 0, 0, n);
        check("illegal_op_funct", {31'b0, illegal_op}, 32'h1);
        do_reset();

        for (int i = 0; i < 80; i++) begin
            logic [5:0] op, fn;
            int         sel, k, ab;
            sel = $urandom_range(0, 15);
            if (sel == 15) begin
                op = 6'($urandom);
                fn = 6'($urandom);
            end else begin
                op = legal_op[sel];
                fn = (op == 6'h00) ? legal_fn[sel] : 6'($urandom);
            end
            k  = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, T);
            ab = ($urandom_range(0, 9) == 0) ? $urandom_range(1, T - 1) : 0;
            run_instr(op, fn, $urandom_range(0, 2), $urandom_range(0, 2), k, ab, n);
            if (ill_m || to_m || (classify(op, fn) == C_MD && ab != 0)) do_reset();
        end

        repeat (3) @(negedge clk);
        check("queue_drained", exp_q.size(), 32'h0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
